// File: rtl/dds_phase_segmenter_if.sv
// FTW load handshake between the DDS controller (master) and the phase segmenter (slave).
interface dds_phase_segmenter_if #(
    parameter int PHASE_WIDTH = 24
);
    logic [PHASE_WIDTH-1:0] ftw_in;
    logic                   ftw_valid;
    logic                   ftw_ready;

    modport master (output ftw_in, output ftw_valid, input ftw_ready);
    modport slave  (input ftw_in, input ftw_valid, output ftw_ready);
endinterface

// File: rtl/dds_phase_segmenter.sv
// Phase accumulator with phase-continuous FTW reload, quadrant folding into ROM address / local
// argument, and a sign flag delayed to match the evaluator. DDS_PHASE_DITHER_EN adds LFSR phase dither.
module dds_phase_segmenter #(
    parameter int PHASE_WIDTH = 24,
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 16,
    parameter int I_widthX    = 2,
    parameter int PIPE_DELAY  = 4
`ifdef DDS_PHASE_DITHER_EN
    ,
    parameter int DITHER_BITS = 4
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         sync_clr,
    dds_phase_segmenter_if.slave         ftw_if,
    output logic [ADDR_WIDTH-1:0]        address_ram_out,
    output logic signed [DATA_WIDTH-1:0] x_argu_out,
    output logic                         negate_out,
    output logic                         valid_out
);
    localparam int F   = PHASE_WIDTH - 2 - ADDR_WIDTH;
    localparam int FB  = F - 1;
    localparam int FR  = DATA_WIDTH - I_widthX;
    localparam int XW  = DATA_WIDTH + F;
    localparam int SHL = (FR > FB) ? (FR - FB) : 0;
    localparam int SHR = (FB > FR) ? (FB - FR) : 0;

    logic [PHASE_WIDTH-1:0]        r_acc;
    logic [PHASE_WIDTH-1:0]        r_ftw_active;
    logic [PHASE_WIDTH-1:0]        r_ftw_pending;
    logic                          r_pend;
    logic [PHASE_WIDTH:0]          w_sum;
    logic                          w_accept;
    logic                          w_apply;
    logic [PHASE_WIDTH-1:0]        w_phase;
    logic [1:0]                    w_q;
    logic [PHASE_WIDTH-3:0]        w_lower;
    logic [ADDR_WIDTH-1:0]         w_seg;
    logic [F-1:0]                  w_t;
    logic signed [F-1:0]           w_m;
    logic signed [DATA_WIDTH-1:0]  w_x;
    logic [ADDR_WIDTH-1:0]         r_addr_p0;
    logic signed [DATA_WIDTH-1:0]  r_x_p0;
    logic                          r_neg_p0;
    logic                          r_vld_p0;
    logic [PIPE_DELAY-1:0]         r_neg_pipe;
    logic [PIPE_DELAY-1:0]         r_vld_pipe;

    // Sign-extend the F-bit argument and left-align its fraction into the output fraction field.
    function automatic logic signed [DATA_WIDTH-1:0] f_align_x(input logic signed [F-1:0] m);
        logic signed [XW-1:0] ext;
        ext = {{(XW-F){m[F-1]}}, m};
        ext = (ext <<< SHL) >>> SHR;
        return ext[DATA_WIDTH-1:0];
    endfunction

    assign ftw_if.ftw_ready = ~r_pend;
    assign w_accept = ftw_if.ftw_valid && !r_pend;
    assign w_sum    = {1'b0, r_acc} + {1'b0, r_ftw_active};
    assign w_apply  = enable && r_pend && (w_sum[PHASE_WIDTH] || (r_ftw_active == '0));

`ifdef DDS_PHASE_DITHER_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_phase   = r_acc + {{(PHASE_WIDTH-DITHER_BITS){1'b0}}, r_lfsr[DITHER_BITS-1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_lfsr <= 16'hACE1;
        else if (enable) r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
`else
    assign w_phase = r_acc;
`endif

    // Accumulator and FTW reload; the add always uses the word active at the start of the cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc         <= '0;
            r_ftw_active  <= '0;
            r_ftw_pending <= '0;
            r_pend        <= 1'b0;
        end else if (sync_clr) begin
            r_acc  <= '0;
            r_pend <= 1'b0;
            if (r_pend)        r_ftw_active <= r_ftw_pending;
            else if (w_accept) r_ftw_active <= ftw_if.ftw_in;
        end else begin
            if (enable) r_acc <= w_sum[PHASE_WIDTH-1:0];
            if (w_apply) begin
                r_ftw_active <= r_ftw_pending;
                r_pend       <= 1'b0;
            end else if (w_accept) begin
                r_ftw_pending <= ftw_if.ftw_in;
                r_pend        <= 1'b1;
            end
        end
    end

    // Quadrant fold: odd quadrants mirror the in-quadrant phase.
    assign w_q     = w_phase[PHASE_WIDTH-1 -: 2];
    assign w_lower = w_phase[PHASE_WIDTH-3:0] ^ {(PHASE_WIDTH-2){w_q[0]}};
    assign w_seg   = w_lower[PHASE_WIDTH-3 -: ADDR_WIDTH];
    assign w_t     = w_lower[F-1:0];
    assign w_m     = {~w_t[F-1], w_t[F-2:0]};
    assign w_x     = f_align_x(w_m);

    // Stage p0: registered address/argument; then PIPE_DELAY stages for sign and valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr_p0  <= '0;
            r_x_p0     <= '0;
            r_neg_p0   <= 1'b0;
            r_vld_p0   <= 1'b0;
            r_neg_pipe <= '0;
            r_vld_pipe <= '0;
        end else if (enable) begin
            r_addr_p0     <= w_seg;
            r_x_p0        <= w_x;
            r_neg_p0      <= w_q[1];
            r_vld_p0      <= 1'b1;
            r_neg_pipe[0] <= r_neg_p0;
            r_vld_pipe[0] <= r_vld_p0;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                r_neg_pipe[i] <= r_neg_pipe[i-1];
                r_vld_pipe[i] <= r_vld_pipe[i-1];
            end
        end
    end

    assign address_ram_out = r_addr_p0;
    assign x_argu_out      = r_x_p0;
    assign negate_out      = r_neg_pipe[PIPE_DELAY-1];
    assign valid_out       = r_vld_pipe[PIPE_DELAY-1];
endmodule
